// File: rtl/match_controller.sv
// Best-of-N tug-of-war match sequencer: countdown, play gating,
// round scoring and champion declaration around the rope datapath.
module match_controller #(
  parameter int ROUNDS_TO_WIN    = 3,
  parameter int COUNTDOWN_CYCLES = 4,
  parameter int HOLD_CYCLES      = 2,
  parameter int SCORE_W          = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               start,
  input  logic               leftwin,
  input  logic               rightwin,
  output logic               round_reset,
  output logic               play_en,
  output logic [SCORE_W-1:0] left_score,
  output logic [SCORE_W-1:0] right_score,
  output logic [SCORE_W-1:0] rounds_played,
  output logic               match_over,
  output logic               left_champ,
  output logic               right_champ
);

  localparam int TMAX = (COUNTDOWN_CYCLES > HOLD_CYCLES)
                        ? COUNTDOWN_CYCLES : HOLD_CYCLES;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] CD_LOAD   = TW'(COUNTDOWN_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(ROUNDS_TO_WIN);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    ROUND_END = 3'd3,
    MATCH_END = 3'd4
  } state_t;

  state_t              state;
  logic [TW-1:0]       timer;
  logic [SCORE_W-1:0]  left_next;
  logic [SCORE_W-1:0]  right_next;
  logic [SCORE_W-1:0]  rounds_next;

  always_comb begin
    left_next   = left_score + 1'b1;
    right_next  = right_score + 1'b1;
    rounds_next = rounds_played;
    if (!(&rounds_played))
      rounds_next = rounds_played + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      timer         <= '0;
      round_reset   <= 1'b1;
      play_en       <= 1'b0;
      left_score    <= '0;
      right_score   <= '0;
      rounds_played <= '0;
      match_over    <= 1'b0;
      left_champ    <= 1'b0;
      right_champ   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          round_reset <= 1'b1;
          play_en     <= 1'b0;
          match_over  <= 1'b0;
          if (start) begin
            state         <= COUNTDOWN;
            timer         <= CD_LOAD;
            left_score    <= '0;
            right_score   <= '0;
            rounds_played <= '0;
            left_champ    <= 1'b0;
            right_champ   <= 1'b0;
          end
        end

        COUNTDOWN: begin
          if (timer == '0) begin
            state       <= PLAY;
            round_reset <= 1'b0;
            play_en     <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        PLAY: begin
          if (leftwin || rightwin) begin
            rounds_played <= rounds_next;
            round_reset   <= 1'b1;
            play_en       <= 1'b0;
            state         <= ROUND_END;
            timer         <= HOLD_LOAD;
            if (leftwin && !rightwin) begin
              left_score <= left_next;
              if (left_next == WIN) begin
                left_champ <= 1'b1;
                match_over <= 1'b1;
                state      <= MATCH_END;
              end
            end else if (rightwin && !leftwin) begin
              right_score <= right_next;
              if (right_next == WIN) begin
                right_champ <= 1'b1;
                match_over  <= 1'b1;
                state       <= MATCH_END;
              end
            end
          end
        end

        ROUND_END: begin
          if (timer == '0) begin
            state <= COUNTDOWN;
            timer <= CD_LOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        MATCH_END: begin
          if (start) begin
            state         <= COUNTDOWN;
            timer         <= CD_LOAD;
            match_over    <= 1'b0;
            left_score    <= '0;
            right_score   <= '0;
            rounds_played <= '0;
            left_champ    <= 1'b0;
            right_champ   <= 1'b0;
          end
        end

        // Illegal encodings fall back to a clean idle
        default: begin
          state         <= IDLE;
          timer         <= '0;
          round_reset   <= 1'b1;
          play_en       <= 1'b0;
          left_score    <= '0;
          right_score   <= '0;
          rounds_played <= '0;
          match_over    <= 1'b0;
          left_champ    <= 1'b0;
          right_champ   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed plus random bench for match_controller against a
// phase/blocked-cycle reference model of the match.
module tb_match_controller;

  localparam int RTW = 3;
  localparam int CD  = 4;
  localparam int HD  = 2;
  localparam int SW  = 3;
  localparam int SAT = (1 << SW) - 1;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          start;
  logic          leftwin;
  logic          rightwin;
  logic          round_reset;
  logic          play_en;
  logic [SW-1:0] left_score;
  logic [SW-1:0] right_score;
  logic [SW-1:0] rounds_played;
  logic          match_over;
  logic          left_champ;
  logic          right_champ;

  match_controller #(
    .ROUNDS_TO_WIN(RTW),
    .COUNTDOWN_CYCLES(CD),
    .HOLD_CYCLES(HD),
    .SCORE_W(SW)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .start(start),
    .leftwin(leftwin),
    .rightwin(rightwin),
    .round_reset(round_reset),
    .play_en(play_en),
    .left_score(left_score),
    .right_score(right_score),
    .rounds_played(rounds_played),
    .match_over(match_over),
    .left_champ(left_champ),
    .right_champ(right_champ)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  // 0 idle, 1 playfield blocked, 2 playing, 3 match over
  int m_mode;
  int m_wait;
  int m_l;
  int m_r;
  int m_rounds;
  int m_lc;
  int m_rc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void m_clear();
    m_l = 0;
    m_r = 0;
    m_rounds = 0;
    m_lc = 0;
    m_rc = 0;
  endfunction

  function automatic void model_step(bit rst, bit st, bit lw, bit rw);
    if (rst) begin
      m_mode = 0;
      m_wait = 0;
      m_clear();
    end else begin
      case (m_mode)
        0, 3: if (st) begin
          m_clear();
          m_mode = 1;
          m_wait = CD;
        end
        1: begin
          m_wait--;
          if (m_wait == 0) m_mode = 2;
        end
        default: if (lw || rw) begin
          if (m_rounds < SAT) m_rounds++;
          if (lw && !rw) m_l++;
          if (rw && !lw) m_r++;
          if (m_l == RTW) begin
            m_lc = 1;
            m_mode = 3;
          end else if (m_r == RTW) begin
            m_rc = 1;
            m_mode = 3;
          end else begin
            m_mode = 1;
            m_wait = HD + CD;
          end
        end
      endcase
    end
  endfunction

  task automatic check_all();
    chk("round_reset", 32'(round_reset), 32'(m_mode != 2));
    chk("play_en", 32'(play_en), 32'(m_mode == 2));
    chk("match_over", 32'(match_over), 32'(m_mode == 3));
    chk("left_score", 32'(left_score), 32'(m_l));
    chk("right_score", 32'(right_score), 32'(m_r));
    chk("rounds", 32'(rounds_played), 32'(m_rounds));
    chk("left_champ", 32'(left_champ), 32'(m_lc));
    chk("right_champ", 32'(right_champ), 32'(m_rc));
    chk("champ_excl", 32'(left_champ & right_champ), 32'd0);
  endtask

  task automatic cycle(input bit rst, input bit st,
                       input bit lw, input bit rw);
    @(negedge Clock);
    check_all();
    Reset = rst;
    start = st;
    leftwin = lw;
    rightwin = rw;
    @(posedge Clock);
    model_step(rst, st, lw, rw);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    leftwin = 1'b0;
    rightwin = 1'b0;
    @(posedge Clock);
    model_step(1, 0, 0, 0);

    cycle(1, 0, 0, 0);
    idle(5);
    cycle(0, 1, 0, 0);
    idle(4);
    #1 chk("play_open", 32'(play_en), 32'd1);

    cycle(0, 0, 1, 0);
    #1 chk("left_first", 32'(left_score), 32'd1);
    cycle(0, 0, 0, 1);
    idle(5);
    #1 chk("hold_ignore", 32'(right_score), 32'd0);

    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 1);
      idle(6);
    end
    #1 chk("rchamp", 32'(right_champ), 32'd1);
    chk("rscore3", 32'(right_score), 32'd3);
    cycle(0, 0, 1, 0);
    idle(2);
    #1 chk("late_left", 32'(left_score), 32'd1);
    cycle(0, 1, 0, 0);
    #1 chk("restart_clr", 32'(right_champ), 32'd0);
    idle(4);

    cycle(0, 0, 1, 1);
    #1 chk("void_rounds", 32'(rounds_played), 32'd1);
    idle(6);

    cycle(0, 0, 1, 0);
    idle(6);
    cycle(0, 0, 1, 0);
    idle(6);
    cycle(0, 0, 0, 1);
    idle(6);
    cycle(1, 0, 1, 0);
    #1 chk("rst_play", 32'(left_score), 32'd0);
    chk("rst_champ", 32'(left_champ), 32'd0);
    idle(2);

    cycle(0, 1, 0, 0);
    idle(4);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, 1, 1);
      idle(6);
    end
    #1 chk("rounds_sat", 32'(rounds_played), 32'(SAT));

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(299) == 0, $urandom_range(7) == 0,
            $urandom_range(4) == 0, $urandom_range(4) == 0);

    @(negedge Clock);
    check_all();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
